// File: rtl/l1c_data_2way.sv
// 2-way set-associative, write-through, no-write-allocate L1 data cache.
// True-LRU replacement, single-cycle flush, uncacheable bypass window, read hit/miss counters.
module l1c_data_2way #(
  parameter int          SETS   = 32,
  parameter int          WORDS  = 4,
  parameter logic [15:0] UNC_HI = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_in,
  input  logic [2:0]  core_type,
  output logic [31:0] core_out,
  output logic        core_wait,
  input  logic        flush,
  output logic        D_req,
  output logic        D_write,
  output logic [31:0] D_addr,
  output logic [31:0] D_in,
  output logic [2:0]  D_type,
  input  logic [31:0] D_out,
  input  logic        D_wait,
  output logic [31:0] rd_hit_cnt,
  output logic [31:0] rd_miss_cnt
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - OB - IB;
  localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);

  // state    | meaning
  // S_IDLE   | waiting for a request or flush
  // S_LOOKUP | tag compare, pick hit way or victim
  // S_FILL   | WORDS-beat line refill into the victim way
  // S_UNC_RD | single-word uncacheable read
  // S_WRITE  | write-through beat, merge into hit way
  // S_DONE   | one cycle with core_wait low
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL, S_UNC_RD, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic [31:0]         req_data_q, req_data_d;
  logic [2:0]          req_type_q, req_type_d;
  logic                req_write_q, req_write_d;
  logic                hit_q, hit_d;
  logic                way_q, way_d;
  logic [OB-1:0]       beat_q, beat_d;
  logic [31:0]         core_out_q, core_out_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic [31:0]         data_q [2][SETS][WORDS];
  logic [TB-1:0]       tag_q  [2][SETS];

  logic                data_we;
  logic [OB-1:0]       data_word;
  logic [31:0]         data_wdata;
  logic                tag_we;

  logic [IB-1:0]       req_idx;
  logic [TB-1:0]       req_tag;
  logic [OB-1:0]       req_word;
  logic                req_unc;
  logic                hit0, hit1, hit;
  logic                victim;
  logic [31:0]         rd0, rd1, old_word, merged;
  logic [3:0]          be;

  assign req_idx  = req_addr_q[IB+OB+1:OB+2];
  assign req_tag  = req_addr_q[31:IB+OB+2];
  assign req_word = req_addr_q[OB+1:2];
  assign req_unc  = (req_addr_q[31:16] == UNC_HI);

  assign rd0  = data_q[0][req_idx][req_word];
  assign rd1  = data_q[1][req_idx][req_word];
  assign hit0 = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1 = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit  = (hit0 || hit1) && !req_unc;

  // lru_q holds the way to evict next; invalid ways are always filled first
  assign victim = !valid_q[0][req_idx] ? 1'b0 :
                  !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  always_comb begin
    be = 4'b1111;
    case (req_type_q[1:0])
      2'd0:    be = 4'b0001 << req_addr_q[1:0];
      2'd1:    be = req_addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign old_word = data_q[way_q][req_idx][req_word];

  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = req_data_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_type_d  = req_type_q;
    req_write_d = req_write_q;
    hit_d       = hit_q;
    way_d       = way_q;
    beat_d      = beat_q;
    core_out_d  = core_out_q;
    valid_d     = valid_q;
    lru_d       = lru_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    data_we     = 1'b0;
    data_word   = req_word;
    data_wdata  = merged;
    tag_we      = 1'b0;
    D_req       = 1'b0;
    D_write     = 1'b0;
    D_addr      = 32'd0;
    D_in        = 32'd0;
    D_type      = 3'd0;
    core_wait   = 1'b1;

    case (state_q)
      S_IDLE: begin
        core_wait = core_req || flush;
        if (flush) begin
          valid_d = '0;
          lru_d   = '0;
        end else if (core_req) begin
          req_addr_d  = core_addr;
          req_data_d  = core_in;
          req_type_d  = core_type;
          req_write_d = core_write;
          state_d     = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        hit_d = hit;
        if (req_write_q) begin
          way_d   = !hit0;
          state_d = S_WRITE;
        end else if (hit) begin
          core_out_d       = hit0 ? rd0 : rd1;
          lru_d[req_idx]   = hit0;
          hit_cnt_d        = hit_cnt_q + 32'd1;
          state_d          = S_DONE;
        end else if (req_unc) begin
          state_d = S_UNC_RD;
        end else begin
          way_d      = victim;
          beat_d     = '0;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        D_req  = 1'b1;
        D_addr = {req_tag, req_idx, beat_q, 2'b00};
        D_type = 3'b010;
        if (!D_wait) begin
          data_we    = 1'b1;
          data_word  = beat_q;
          data_wdata = D_out;
          if (beat_q == req_word) core_out_d = D_out;
          if (beat_q == LAST_BEAT) begin
            tag_we                = 1'b1;
            valid_d[way_q][req_idx] = 1'b1;
            lru_d[req_idx]        = ~way_q;
            beat_d                = '0;
            state_d               = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_UNC_RD: begin
        D_req  = 1'b1;
        D_addr = req_addr_q;
        D_type = req_type_q;
        if (!D_wait) begin
          core_out_d = D_out;
          state_d    = S_DONE;
        end
      end

      S_WRITE: begin
        D_req   = 1'b1;
        D_write = 1'b1;
        D_addr  = req_addr_q;
        D_in    = req_data_q;
        D_type  = req_type_q;
        if (!D_wait) begin
          if (hit_q) begin
            data_we        = 1'b1;
            lru_d[req_idx] = ~way_q;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        core_wait = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_addr_q  <= 32'd0;
      req_data_q  <= 32'd0;
      req_type_q  <= 3'd0;
      req_write_q <= 1'b0;
      hit_q       <= 1'b0;
      way_q       <= 1'b0;
      beat_q      <= '0;
      core_out_q  <= 32'd0;
      valid_q     <= '0;
      lru_q       <= '0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_type_q  <= req_type_d;
      req_write_q <= req_write_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      beat_q      <= beat_d;
      core_out_q  <= core_out_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // storage arrays need no reset: nothing is visible until its valid bit is set
  always_ff @(posedge clk) begin
    if (rst && data_we) data_q[way_q][req_idx][data_word] <= data_wdata;
    if (rst && tag_we)  tag_q[way_q][req_idx] <= req_tag;
  end

  assign core_out    = core_out_q;
  assign rd_hit_cnt  = hit_cnt_q;
  assign rd_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l1c_data_2way.sv
// Directed bench for l1c_data_2way: memory responder with configurable wait states
// and hand-computed expectations for latency, data, beats and counters.
module tb_l1c_data_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0, core_write = 1'b0, flush = 1'b0;
  logic [31:0] core_addr = 32'd0, core_in = 32'd0;
  logic [2:0]  core_type = 3'd0;
  logic [31:0] core_out;
  logic        core_wait;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        D_wait;
  logic [31:0] rd_hit_cnt, rd_miss_cnt;

  l1c_data_2way #(.SETS(32), .WORDS(4), .UNC_HI(16'h1000)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_write(core_write), .core_addr(core_addr),
    .core_in(core_in), .core_type(core_type), .core_out(core_out),
    .core_wait(core_wait), .flush(flush),
    .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in),
    .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
    .rd_hit_cnt(rd_hit_cnt), .rd_miss_cnt(rd_miss_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  logic [31:0] unc_val = 32'hDEAD_BEEF;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          rd_beats = 0, wr_beats = 0, req_cycles = 0;
  logic [31:0] beat_addr [64];
  logic [31:0] last_wr_addr = 32'd0, last_wr_data = 32'd0;
  logic [2:0]  last_wr_type = 3'd0, last_rd_type = 3'd0;

  always_comb begin
    D_wait = (wait_cnt < wait_cfg);
    D_out  = (D_addr[31:16] == 16'h1000) ? unc_val : mem[D_addr[13:2]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 0;
    end else if (D_req) begin
      req_cycles <= req_cycles + 1;
      if (D_wait) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (D_write) begin
          wr_beats     <= wr_beats + 1;
          last_wr_addr <= D_addr;
          last_wr_data <= D_in;
          last_wr_type <= D_type;
        end else begin
          beat_addr[rd_beats % 64] <= D_addr;
          rd_beats     <= rd_beats + 1;
          last_rd_type <= D_type;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issues one request in the current (IDLE) cycle; lat = cycle index of DONE.
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input logic [2:0] typ, output int lat, output logic [31:0] dout);
    core_req = 1'b1; core_write = wr; core_addr = addr; core_in = data; core_type = typ;
    @(posedge clk); #1;
    lat = 1;
    core_req = 1'b0; core_write = ~wr; core_addr = 32'hFFFF_FFFC;
    core_in = 32'hFFFF_FFFF; core_type = 3'b111;
    while (core_wait && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = core_out;
    @(posedge clk); #1;
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input int exp_lat,
                    input logic [31:0] exp_data);
    int lat;
    logic [31:0] d;
    access(addr, 1'b0, 32'd0, 3'b010, lat, d);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, d, exp_data);
  endtask

  initial begin
    int lat, r0, w0, q0;
    logic [31:0] d;

    for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 | 32'(i << 2);
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'hA0 + 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_core_wait", {31'd0, core_wait}, 32'd0);
    check("rst_d_req", {31'd0, D_req}, 32'd0);
    check("rst_d_write", {31'd0, D_write}, 32'd0);
    check("rst_d_addr", D_addr, 32'd0);
    check("rst_d_in", D_in, 32'd0);
    check("rst_d_type", {29'd0, D_type}, 32'd0);
    check("rst_core_out", core_out, 32'd0);
    check("rst_hit_cnt", rd_hit_cnt, 32'd0);
    check("rst_miss_cnt", rd_miss_cnt, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // cold miss then hit
    r0 = rd_beats;
    ld("cold", 32'h0000_0104, 6, 32'hA1);
    check("cold_beats", 32'(rd_beats - r0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_beat_addr", beat_addr[(r0 + i) % 64], 32'h100 + 32'(4 * i));
    check("cold_rd_type", {29'd0, last_rd_type}, 32'd2);
    check("cold_miss_cnt", rd_miss_cnt, 32'd1);
    check("cold_hit_cnt", rd_hit_cnt, 32'd0);
    q0 = req_cycles;
    ld("rehit", 32'h0000_0104, 2, 32'hA1);
    check("rehit_no_dreq", 32'(req_cycles - q0), 32'd0);
    check("rehit_hit_cnt", rd_hit_cnt, 32'd1);

    // LRU: A=0x100, B=0x300, C=0x500 share set 16
    ld("lru_b", 32'h0000_0300, 6, 32'hC000_0300);
    ld("lru_a", 32'h0000_0100, 2, 32'hA0);
    ld("lru_c", 32'h0000_0500, 6, 32'hC000_0500);
    ld("lru_a2", 32'h0000_0100, 2, 32'hA0);
    ld("lru_b2", 32'h0000_0300, 6, 32'hC000_0300);
    check("lru_hit_cnt", rd_hit_cnt, 32'd3);
    check("lru_miss_cnt", rd_miss_cnt, 32'd4);

    // uncached read with 3 wait states
    wait_cfg = 3;
    q0 = req_cycles;
    ld("unc", 32'h1000_0008, 6, 32'hDEAD_BEEF);
    check("unc_dreq_cycles", 32'(req_cycles - q0), 32'd4);
    check("unc_rd_type", {29'd0, last_rd_type}, 32'd2);
    r0 = rd_beats;
    ld("unc_again", 32'h1000_0008, 6, 32'hDEAD_BEEF);
    check("unc_again_beats", 32'(rd_beats - r0), 32'd1);
    check("unc_hit_cnt", rd_hit_cnt, 32'd3);
    check("unc_miss_cnt", rd_miss_cnt, 32'd4);
    wait_cfg = 0;

    // flush, refill A with new contents
    flush = 1'b1;
    #1;
    check("flush_wait", {31'd0, core_wait}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_release", {31'd0, core_wait}, 32'd0);
    mem[64] = 32'h1122_3344;
    r0 = rd_beats;
    ld("post_flush", 32'h0000_0100, 6, 32'h1122_3344);
    check("post_flush_beats", 32'(rd_beats - r0), 32'd4);
    check("post_flush_miss", rd_miss_cnt, 32'd5);

    // store byte hit
    r0 = rd_beats; w0 = wr_beats;
    access(32'h0000_0101, 1'b1, 32'h0000_5500, 3'd0, lat, d);
    check("stb_lat", 32'(lat), 32'd3);
    check("stb_wr_beats", 32'(wr_beats - w0), 32'd1);
    check("stb_no_fill", 32'(rd_beats - r0), 32'd0);
    check("stb_wr_addr", last_wr_addr, 32'h0000_0101);
    check("stb_wr_data", last_wr_data, 32'h0000_5500);
    check("stb_wr_type", {29'd0, last_wr_type}, 32'd0);
    q0 = req_cycles;
    ld("stb_reload", 32'h0000_0100, 2, 32'h1122_5544);
    check("stb_reload_no_dreq", 32'(req_cycles - q0), 32'd0);

    // uncached store and cacheable miss store: memory only
    r0 = rd_beats; w0 = wr_beats;
    access(32'h1000_0100, 1'b1, 32'h1234_5678, 3'd2, lat, d);
    check("unc_st_lat", 32'(lat), 32'd3);
    check("unc_st_wr_beats", 32'(wr_beats - w0), 32'd1);
    check("unc_st_no_fill", 32'(rd_beats - r0), 32'd0);
    ld("unc_st_reload", 32'h0000_0100, 2, 32'h1122_5544);
    access(32'h0000_0700, 1'b1, 32'h0BAD_F00D, 3'd2, lat, d);
    check("miss_st_lat", 32'(lat), 32'd3);
    ld("miss_st_noalloc", 32'h0000_0700, 6, 32'hC000_0700);
    check("st_hit_cnt", rd_hit_cnt, 32'd5);

    // reset during third fill beat
    core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_0208; core_type = 3'd2;
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("beat3_addr", D_addr, 32'h0000_0208);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_fill_dreq", {31'd0, D_req}, 32'd0);
    check("rst_fill_miss_cnt", rd_miss_cnt, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_fill_wait", {31'd0, core_wait}, 32'd0);
    r0 = rd_beats;
    ld("rst_reload", 32'h0000_0208, 6, 32'hC000_0208);
    check("rst_reload_beats", 32'(rd_beats - r0), 32'd4);
    check("rst_reload_miss", rd_miss_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/l1c_data_2way.md
# l1c_data_2way

Parametrised successor to the direct-mapped L1 data cache: a 2-way set-associative, write-through, no-write-allocate data cache with configurable set count and line length. It sits between the CPU core's data port and the CPU-wrapper data master (`D_*`). It adds true-LRU replacement, a single-cycle flush and read hit/miss counters. Addresses in the uncacheable window (sensor/MMIO) bypass the arrays as single-word accesses. Tag, valid, LRU and data storage are internal flop arrays.

## Interface
Parameters:
- `SETS`, 32: sets per way; power of 2, ≥2.
- `WORDS`, 4: 32-bit words per line; power of 2, ≥2.
- `UNC_HI`, 16'h1000: an address is uncacheable when `addr[31:16] == UNC_HI`.

Ports (OB = log2 WORDS, IB = log2 SETS, TB = 30−OB−IB):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **reset is synchronous and active-low**; sampled on `clk` rising edge while 0.
- `core_req` in 1: request valid.
- `core_write` in 1: 1 = store, 0 = load.
- `core_addr` in 32: byte address.
- `core_in` in 32: store data, already lane-aligned.
- `core_type` in 3: 0/4 byte, 1/5 half, 2 word.
- `core_out` out 32: full aligned load word, registered. The core performs extraction and sign extension.
- `core_wait` out 1: stall.
- `flush` in 1: invalidate all lines.
- `D_req` out 1, `D_write` out 1, `D_addr` out 32, `D_in` out 32, `D_type` out 3: memory request.
- `D_out` in 32, `D_wait` in 1: memory response.
- `rd_hit_cnt` out 32, `rd_miss_cnt` out 32: performance counters.

## Operation
- Address split: `[1:0]` byte, `[OB+1:2]` word, `[IB+OB+1:OB+2]` index, `[31:IB+OB+2]` tag (TB bits).
- States: IDLE, LOOKUP, FILL, UNC_RD, WRITE, DONE.
- IDLE:
  - `flush`=1 clears all valid and LRU bits this cycle and holds `core_wait`=1. Flush has priority over `core_req`.
  - Otherwise `core_req`=1 latches addr, data, type and write into request registers and moves to LOOKUP.
- LOOKUP: hit = valid && tag match in either way && cacheable.
  - Read hit: latch the word into `core_out`, set LRU to the other way, go to DONE, increment `rd_hit_cnt`.
  - Read miss, cacheable: go to FILL, increment `rd_miss_cnt`.
  - Read, uncacheable: go to UNC_RD. No counter changes.
  - Write: go to WRITE. Record the hit way.
- FILL:
  - Victim is the first invalid way (way0 first); otherwise the LRU way.
  - Issues WORDS single-word reads: `D_addr` = {tag, index, beat, 2'b00}, `D_type`=3'b010, beat 0..WORDS−1.
  - Each cycle with `D_wait`=0 is one beat: `D_out` is written to that word of the victim, beat increments, and `core_out` is latched when beat equals the requested word.
  - On the last beat: write tag, set valid, set LRU to the other way, go to DONE.
- UNC_RD: `D_addr` = request address, `D_type` = request type. On the `D_wait`=0 beat, latch `core_out` from `D_out` and go to DONE. The arrays are untouched.
- WRITE:
  - `D_req`=`D_write`=1, `D_addr`/`D_in`/`D_type` come from the request registers.
  - On the `D_wait`=0 beat:
    - On hit, merge the byte lanes into the hit way: byte writes lane `addr[1:0]`; half writes lanes `{addr[1],0}` and +1; word writes all lanes. Set LRU to the other way.
    - Then go to DONE.
  - Miss or uncacheable: memory only, no allocation.
- DONE: `core_wait`=0 for exactly one cycle, then IDLE. A request present in the IDLE cycle that follows is accepted normally.
- `core_wait` = 1 in every state except DONE, and in IDLE when `core_req` or `flush` is 1.
- Counters wrap modulo 2^32.

## Timing
- Reset values: state IDLE; all valid, LRU, beat and counters 0; `core_out`=0; `D_req`=`D_write`=0; `D_addr`=`D_in`=0; `D_type`=0.
- With `core_req`=0 and `flush`=0 during reset, `core_wait`=0.
- `D_*` outputs are 0 outside FILL, UNC_RD and WRITE.
- `D_req` is held continuously and the address is stable until the accepting `D_wait`=0 beat. No gap cycles occur between fill beats.
- Latency, with the request at cycle 0:
  - Read hit: DONE at cycle 2.
  - Uncached read or write with zero wait states: DONE at cycle 3.
  - Miss with zero wait states: DONE at cycle 2+WORDS.
- Request fields are ignored after the IDLE capture; changes mid-access have no effect.
- `flush` outside IDLE is ignored; the requester holds it until `core_wait`=0.
- `rst`=0 mid-FILL or mid-WRITE: next edge returns to IDLE and drops `D_req`.
  - Valid is cleared, so a partial line is never visible.
  - The memory side discards the abandoned transaction.

## Test plan
- Reset, then load at 0x0000_0104 (cold) with WORDS=4 and memory returning 0xA0..0xA3 for 0x100..0x10C. Required: four beats at 0x100, 0x104, 0x108, 0x10C; `core_out`=0xA1 at cycle 6; `rd_miss_cnt`=1. Repeat load: `core_out`=0xA1 at cycle 2, `rd_hit_cnt`=1, `D_req` never asserted.
- Three conflicting lines A=0x0000_0100, B=A+SETS·16, C=A+2·SETS·16; sequence load A, B, A, C.
  - Required: C evicts B (LRU).
  - A subsequent load of A hits; a load of B misses.
- Store byte 0x55 to 0x0000_0101 (hit, line word 0x11223344).
  - Required: a single D beat with `D_write`=1.
  - A reload returns 0x11225544.
  - A store to an uncached line produces no fill and leaves the cache unchanged.
- Load at 0x1000_0008 with 3 `D_wait` cycles and `D_out`=0xDEAD_BEEF.
  - Required: `core_out`=0xDEADBEEF in DONE.
  - No counters change; a reload goes to memory again.
- Pulse `flush` in IDLE after filling A, then load A. Required: a miss with a full refill.
- `rst`=0 during the third fill beat, then load the same address. Required: a miss with four beats.
